// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite rasteriser: FSM state encoding,
// visible-area limits and the packed RGB pixel type.
package sprite_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ROW = 3'd1,
        WAIT_COL = 3'd2,
        DRAW     = 3'd3,
        LINE_END = 3'd4,
        DONE     = 3'd5
    } sprite_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator: column/replication/row counters plus a row base
// accumulator, so the address is base + col without any multiplier.
module sprite_addr_gen #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 8,
    parameter int SCALE    = 1,
    parameter int ADDR_W   = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic              line_end_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_col_o,
    output logic              last_row_o
);

    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int HW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     hrep_q, hrep_d;
    logic [RW-1:0]     vrep_q, vrep_d;
    logic [HW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic col_end, hrep_end, vrep_end, row_end;

    assign col_end  = (col_q == CW'(SPRITE_W - 1));
    assign hrep_end = (hrep_q == RW'(SCALE - 1));
    assign vrep_end = (vrep_q == RW'(SCALE - 1));
    assign row_end  = (row_q == HW'(SPRITE_H - 1));

    assign addr_o     = base_q + ADDR_W'(col_q);
    assign last_col_o = col_end && hrep_end;
    assign last_row_o = row_end && vrep_end;

    always_comb begin
        col_d  = col_q;
        hrep_d = hrep_q;
        vrep_d = vrep_q;
        row_d  = row_q;
        base_d = base_q;
        if (clr_i) begin
            col_d  = '0;
            hrep_d = '0;
            vrep_d = '0;
            row_d  = '0;
            base_d = '0;
        end else if (step_i) begin
            if (hrep_end) begin
                hrep_d = '0;
                // Hold on the last column so col never exceeds SPRITE_W-1.
                if (!col_end) col_d = col_q + CW'(1);
            end else begin
                hrep_d = hrep_q + RW'(1);
            end
        end else if (line_end_i) begin
            col_d  = '0;
            hrep_d = '0;
            if (vrep_end) begin
                vrep_d = '0;
                // Base stays on the final row so it never wraps inside a frame.
                if (!row_end) begin
                    row_d  = row_q + HW'(1);
                    base_d = base_q + ADDR_W'(SPRITE_W);
                end
            end else begin
                vrep_d = vrep_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q  <= '0;
            hrep_q <= '0;
            vrep_q <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            hrep_q <= hrep_d;
            vrep_q <= vrep_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// Per-sprite rasteriser: frame-latched origin, scan FSM and a two-stage
// address/colour pipeline. Define SPRITE_TRANSPARENCY_EN to enable colour keying.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int          SPRITE_W  = 16,
    parameter int          SPRITE_H  = 8,
    parameter int          SCALE     = 1,
    parameter int          ADDR_W    = $clog2(SPRITE_W * SPRITE_H),
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_ce,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              enable,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sprite_on,
    output logic [7:0]        sprite_R,
    output logic [7:0]        sprite_G,
    output logic [7:0]        sprite_B,
    output logic [2:0]        dbg_state_o
);

    sprite_state_e     state_q, state_d;
    logic [9:0]        lat_x_q, lat_y_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              hit_q;
    logic              on_q;
    rgb_t              rgb_q;

    logic              frame_start;
    logic              draw_px;
    logic              line_end;
    logic [ADDR_W-1:0] gen_addr;
    logic              last_col;
    logic              last_row;
    logic              transparent;
    logic              opaque_hit;

    assign frame_start = pix_ce && (DrawX == 10'd0) && (DrawY == 10'd0);

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .SCALE    (SCALE),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .clr_i      (frame_start),
        .step_i     (draw_px),
        .line_end_i (line_end),
        .addr_o     (gen_addr),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    // draw_px marks a pixel inside the window, including the first one found
    // by WAIT_COL (or WAIT_ROW when the origin column is 0).
    always_comb begin
        state_d  = state_q;
        draw_px  = 1'b0;
        line_end = 1'b0;
        if (pix_ce) begin
            if (frame_start) begin
                state_d = enable ? WAIT_ROW : IDLE;
            end else begin
                case (state_q)
                    WAIT_ROW: begin
                        if (DrawY == lat_y_q) begin
                            state_d = WAIT_COL;
                            draw_px = (DrawX == lat_x_q);
                        end
                    end
                    WAIT_COL: draw_px = (DrawX == lat_x_q);
                    DRAW:     draw_px = 1'b1;
                    LINE_END: begin
                        line_end = 1'b1;
                        state_d  = last_row ? DONE : WAIT_COL;
                    end
                    default:  state_d = state_q;
                endcase
                if (draw_px) begin
                    state_d = (last_col || (DrawX == 10'(H_VISIBLE - 1))) ? LINE_END : DRAW;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            lat_x_q <= '0;
            lat_y_q <= '0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                lat_x_q <= pos_x;
                lat_y_q <= pos_y;
            end
        end
    end

`ifdef SPRITE_TRANSPARENCY_EN
    assign transparent = (rom_data == KEY_COLOR);
`else
    logic unused_key;
    assign unused_key  = ^KEY_COLOR;
    assign transparent = 1'b0;
`endif

    assign opaque_hit = hit_q && !transparent;

    // Stage 1 registers the address of pixel X; stage 2, one pix_ce later,
    // takes the ROM word that has settled in between.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            on_q       <= 1'b0;
            rgb_q      <= '0;
        end else if (pix_ce) begin
            hit_q <= draw_px;
            if (draw_px) rom_addr_q <= gen_addr;
            on_q  <= opaque_hit;
            rgb_q <= opaque_hit ? rgb_t'(rom_data) : '0;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sprite_on   = on_q;
    assign sprite_R    = rgb_q.r;
    assign sprite_G    = rgb_q.g;
    assign sprite_B    = rgb_q.b;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: a SCALE=1 and a SCALE=2 instance share
// the scan inputs, each with its own 1-cycle synchronous ROM model.
module tb_sprite_renderer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       enable = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;

  logic [6:0]  addr1, addr2;
  logic [23:0] data1 = '0, data2 = '0;
  logic        on1, on2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  logic [2:0]  dbg1, dbg2;

  int tests_run = 0;
  int tests_failed = 0;

  bit prev_in[2];
  int prev_addr[2];

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  always #5 Clk = ~Clk;

  sprite_renderer #(.SPRITE_W(16), .SPRITE_H(8), .SCALE(1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
    .enable(enable), .pos_x(pos_x), .pos_y(pos_y), .rom_addr(addr1), .rom_data(data1),
    .sprite_on(on1), .sprite_R(r1), .sprite_G(g1), .sprite_B(b1), .dbg_state_o(dbg1)
  );

  sprite_renderer #(.SPRITE_W(16), .SPRITE_H(8), .SCALE(2)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
    .enable(enable), .pos_x(pos_x), .pos_y(pos_y), .rom_addr(addr2), .rom_data(data2),
    .sprite_on(on2), .sprite_R(r2), .sprite_G(g2), .sprite_B(b2), .dbg_state_o(dbg2)
  );

  function automatic logic [23:0] rom_color(int a);
    if (a == 5) return 24'hFF00FF;
    return {8'(a * 3 + 1), 8'(a ^ 'h3C), 8'(240 - a)};
  endfunction

  always @(posedge Clk) begin
    data1 <= rom_color(int'(addr1));
    data2 <= rom_color(int'(addr2));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_ce = 1'b1;
    @(negedge Clk);
    pix_ce = 1'b0;
  endtask

  // Expected behaviour derived from the sprite geometry, not from the DUT.
  task automatic check_px(input int k, input int x, input int y, input int ox, input int oy,
                          input int s, input bit en, input int got_addr, input bit got_on,
                          input logic [23:0] got_rgb);
    bit in_win;
    int a;
    bit exp_on;
    logic [23:0] exp_rgb;
    in_win = en && x >= ox && x < ox + 16 * s && x <= 639 && y >= oy && y < oy + 8 * s;
    a = ((y - oy) / s) * 16 + (x - ox) / s;
    if (in_win) check_eq($sformatf("u%0d_addr x=%0d y=%0d", k + 1, x, y), got_addr, a);
    exp_on = prev_in[k] && !(TRANSP && rom_color(prev_addr[k]) == 24'hFF00FF);
    exp_rgb = exp_on ? rom_color(prev_addr[k]) : 24'h0;
    check_eq($sformatf("u%0d_on x=%0d y=%0d", k + 1, x, y), 32'(got_on), 32'(exp_on));
    check_eq($sformatf("u%0d_rgb x=%0d y=%0d", k + 1, x, y), 32'(got_rgb), 32'(exp_rgb));
    prev_in[k] = in_win;
    if (in_win) prev_addr[k] = a;
  endtask

  task automatic scan(input int y0, input int y1, input int x0, input int x1,
                      input int ox, input int oy, input bit en);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        pix(x, y);
        check_px(0, x, y, ox, oy, 1, en, int'(addr1), on1, {r1, g1, b1});
        check_px(1, x, y, ox, oy, 2, en, int'(addr2), on2, {r2, g2, b2});
      end
    end
  endtask

  task automatic frame_start();
    pix(0, 0);
    prev_in[0] = 1'b0;
    prev_in[1] = 1'b0;
  endtask

  initial begin
    // Clock/reset
    repeat (3) @(negedge Clk);
    check_eq("rst_addr", 32'(addr1), 32'd0);
    check_eq("rst_on", 32'(on1), 32'd0);
    check_eq("rst_rgb", 32'({r1, g1, b1}), 32'd0);
    check_eq("rst_state", 32'(dbg2), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Frame A: origin (100,50); pos_x moved mid-frame must be ignored
    enable = 1'b1;
    pos_x = 10'd100;
    pos_y = 10'd50;
    frame_start();
    scan(45, 52, 98, 134, 100, 50, 1'b1);
    pos_x = 10'd200;
    scan(53, 70, 98, 134, 100, 50, 1'b1);
    check_eq("a_hold_addr1", 32'(addr1), 32'd127);
    check_eq("a_hold_addr2", 32'(addr2), 32'd127);
    check_eq("a_done1", 32'(dbg1), 32'd5);
    check_eq("a_done2", 32'(dbg2), 32'd5);

    // Frame B: new origin (200,50) takes effect; reset asserted mid-DRAW
    frame_start();
    scan(49, 51, 198, 234, 200, 50, 1'b1);
    scan(52, 52, 198, 205, 200, 50, 1'b1);
    check_eq("b_pre_rst_on", 32'(on1), 32'd1);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_eq("b_rst_on1", 32'(on1), 32'd0);
    check_eq("b_rst_rgb1", 32'({r1, g1, b1}), 32'd0);
    check_eq("b_rst_on2", 32'(on2), 32'd0);
    check_eq("b_rst_addr1", 32'(addr1), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    prev_in[0] = 1'b0;
    prev_in[1] = 1'b0;
    scan(53, 53, 198, 234, 200, 50, 1'b0);
    check_eq("b_idle_addr1", 32'(addr1), 32'd0);
    check_eq("b_idle_state1", 32'(dbg1), 32'd0);

    // Frame C: right-edge clip at pos_x=630
    pos_x = 10'd630;
    pos_y = 10'd10;
    frame_start();
    scan(9, 12, 628, 645, 630, 10, 1'b1);
    check_eq("c_clip_addr1", 32'(addr1), 32'd41);
    check_eq("c_clip_addr2", 32'(addr2), 32'd20);

    // Frame D: sprite disabled
    enable = 1'b0;
    frame_start();
    scan(9, 11, 628, 642, 630, 10, 1'b0);
    check_eq("d_idle_state1", 32'(dbg1), 32'd0);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised sprite rasteriser for the VGA pipeline: compares the scan position (DrawX/DrawY) with a per-frame latched sprite origin and generates the sprite ROM address. It then returns the pixel colour, with optional integer scaling and a colour-key transparency feature. One instance per sprite (player, enemy rows, shields, background tiles) sits between the VGA controller and the colour mapper, replacing ad-hoc full-frame drawers.

## Interface
Parameters:
- SPRITE_W, 16, source sprite width in pixels (≥1)
- SPRITE_H, 8, source sprite height in pixels (≥1)
- SCALE, 1, integer replication factor, applied both horizontally and vertically (1..8)
- ADDR_W, $clog2(SPRITE_W*SPRITE_H), ROM address width
- KEY_COLOR, 24'hFF00FF, transparent colour (used only with SPRITE_TRANSPARENCY_EN)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel enable; one Clk pulse per DrawX step, pulses ≥2 Clk apart
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- enable  in  1  sprite visible; sampled at frame start
- pos_x  in  10  sprite origin column; sampled at frame start
- pos_y  in  10  sprite origin row; sampled at frame start
- rom_addr  out  ADDR_W  sprite ROM read address; synchronous ROM, 1-Clk latency
- rom_data  in  24  {R,G,B} from ROM
- sprite_on  out  1  current output pixel belongs to sprite
- sprite_R, sprite_G, sprite_B  out  8 each  pixel colour; 0 when sprite_on=0

## Operation
- Frame start: pix_ce && DrawX==0 && DrawY==0. Latches enable, pos_x, pos_y; clears row, rep and base counters; goes to WAIT_ROW if enable, else IDLE. Overrides every state. Origin changes mid-frame have no effect until the next frame.
- FSM states and transitions, all evaluated on pix_ce:
  - IDLE: wait for frame start.
  - WAIT_ROW: when DrawY==lat_y, go to WAIT_COL.
  - WAIT_COL: when DrawX==lat_x, go to DRAW; col=0, hrep=0.
  - DRAW: emit address base+col. hrep counts 0..SCALE-1, then col increments. Go to LINE_END after the last col/hrep, or when DrawX==639 (clip).
  - LINE_END: vrep increments. When vrep wraps at SCALE, base += SPRITE_W and row++. After the last row, go to DONE; otherwise go to WAIT_COL.
  - DONE: wait for frame start.
- Address arithmetic uses the accumulator only, no multiplier. Widths are ADDR_W and never wrap inside a frame.
- Clipping:
  - pos_x + SPRITE_W*SCALE > 640: columns beyond 639 are dropped, and the next line restarts at col 0 of the next source row.
  - pos_y beyond the visible area: DONE is never reached, and the next frame start recovers.
- Outside DRAW: sprite_on=0 and RGB=0. rom_addr holds its last value.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Stage 1, on the pix_ce of pixel X: registers rom_addr and the hit flag.
- Stage 2, on the next pix_ce (ROM data is already valid): registers sprite_on and RGB.
- Result: the output for pixel X is presented while DrawX==X+1, a fixed 1-pixel latency. The colour mapper compensates.
- Reset_n low mid-DRAW: outputs go to 0 immediately (asynchronous). After release, the block stays IDLE until the next frame start.
- enable is not sampled mid-frame; deassertion takes effect at the next frame start.

## Configuration
- SPRITE_TRANSPARENCY_EN defined: a stage-2 pixel whose rom_data==KEY_COLOR produces sprite_on=0 and RGB=0, and the background shows through.
- SPRITE_TRANSPARENCY_EN undefined: every in-window pixel is opaque and KEY_COLOR is ignored.

## Structure
- Package sprite_pkg holds: the state enum, H_VISIBLE=640, V_VISIBLE=480, and the rgb_t typedef {8'R,8'G,8'B}.
- Sub-module sprite_addr_gen holds the col/hrep/vrep/row/base counters and produces the address and last-column/last-row flags. The FSM and output pipeline stay in sprite_renderer.

## Test plan
- W=16, H=8, SCALE=1, origin (100,50): DrawX=100/DrawY=50 → rom_addr=0; DrawX=115 → 15; row 51, DrawX=100 → 16; row 57, DrawX=115 → 127. Then DONE, and sprite_on=0 for the rest of the frame.
- SCALE=2, same origin: DrawX 100 and 101 → addr 0; 102 → 1; rows 50 and 51 use base 0; row 52 uses base 16; the last sprite row is 65.
- Clip, pos_x=630: DrawX 630..639 → addr 0..9; the next line restarts at addr 16; no out-of-range address is produced.
- pos_x changed 100→200 at DrawY=53: the rest of the frame is still drawn at 100; the next frame is drawn at 200. Reset_n low during DRAW: outputs 0 within the same Clk.
- Transparency enabled, rom_data=24'hFF00FF at addr 5: sprite_on=0 for that pixel; neighbours are on with their ROM colour. With the macro undefined, the same pixel has sprite_on=1 and RGB=FF/00/FF.
